// File: rtl/mem_burst_master.sv
// Burst master for a synchronous single-port SRAM on a shared tri-state bus.
// Optional feature macro: MEM_ADDR_WRAP_EN (wrap at end of memory instead of rejecting).
module mem_burst_master #(
    parameter int DW = 32,
    parameter int AW = 10,
    parameter int LW = 5
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_req,
    input  logic          i_we,
    input  logic [AW-1:0] i_base,
    input  logic [LW-1:0] i_len,
    input  logic [DW-1:0] i_wdata,
    output logic          o_wreq,
    output logic [DW-1:0] o_rdata,
    output logic          o_rvalid,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_err,
    output logic [AW-1:0] o_addr,
    output logic          o_WR,
    output logic          o_CS,
    inout  wire  [DW-1:0] io_dbus
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD      = 3'd1,
        RD_TAIL = 3'd2,
        WR      = 3'd3,
        GAP     = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [LW-1:0] rem_q, rem_d;
    logic          cs_q, cs_d;
    logic          wr_q, wr_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          rvalid_q, rvalid_d;
    logic          rd_pend_q, rd_pend_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          reject;

`ifdef MEM_ADDR_WRAP_EN
    // Bursts simply roll over the top of memory.
    assign reject = 1'b0;
`else
    localparam logic [AW:0] MEM_WORDS = {1'b1, {AW{1'b0}}};
    logic [AW:0] end_sum;

    // One past the last word touched; must not exceed the memory size.
    assign end_sum = {1'b0, i_base} + {{(AW+1-LW){1'b0}}, i_len};
    assign reject  = (i_len != '0) && (end_sum > MEM_WORDS);
`endif

    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state plus burst address / remaining-word counter.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        unique case (state_q)
            IDLE: begin
                if (i_req) begin
                    if (i_len == '0) begin
                        state_d = GAP;
                    end else if (!reject) begin
                        state_d = i_we ? WR : RD;
                        addr_d  = i_base;
                        rem_d   = i_len - LW'(1);
                    end
                end
            end
            RD: begin
                if (rem_q == '0) begin
                    state_d = RD_TAIL;
                end else begin
                    addr_d = addr_q + AW'(1);
                    rem_d  = rem_q - LW'(1);
                end
            end
            WR: begin
                if (rem_q == '0) begin
                    state_d = GAP;
                end else begin
                    addr_d = addr_q + AW'(1);
                    rem_d  = rem_q - LW'(1);
                end
            end
            RD_TAIL: state_d = GAP;
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output decode: memory controls follow the upcoming state so they register cleanly.
    always_comb begin
        cs_d      = !((state_d == RD) || (state_d == RD_TAIL) || (state_d == WR));
        wr_d      = (state_d == WR);
        busy_d    = (state_d != IDLE);
        done_d    = (state_d == GAP);
        err_d     = (state_q == IDLE) && i_req && reject;
        rd_pend_d = (state_q == RD);
        rvalid_d  = rd_pend_q;
        rdata_d   = rd_pend_q ? io_dbus : rdata_q;
        o_wreq    = (state_q == WR);
    end

    // Registered outputs and burst datapath.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            addr_q    <= '0;
            rem_q     <= '0;
            cs_q      <= 1'b1;
            wr_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            rvalid_q  <= 1'b0;
            rd_pend_q <= 1'b0;
            rdata_q   <= '0;
        end else begin
            addr_q    <= addr_d;
            rem_q     <= rem_d;
            cs_q      <= cs_d;
            wr_q      <= wr_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            rvalid_q  <= rvalid_d;
            rd_pend_q <= rd_pend_d;
            rdata_q   <= rdata_d;
        end
    end

    assign io_dbus  = (!cs_q && wr_q) ? i_wdata : {DW{1'bz}};
    assign o_addr   = addr_q;
    assign o_CS     = cs_q;
    assign o_WR     = wr_q;
    assign o_busy   = busy_q;
    assign o_done   = done_q;
    assign o_err    = err_q;
    assign o_rvalid = rvalid_q;
    assign o_rdata  = rdata_q;

endmodule

// File: tb/tb_mem_burst_master.sv
// Randomized bench for mem_burst_master with an SRAM model and a cycle-level reference.
// Build with MEM_ADDR_WRAP_EN defined or not; the reference follows the same macro.
module tb_mem_burst_master;

    localparam int DW    = 32;
    localparam int AW    = 10;
    localparam int LW    = 5;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          req;
    logic          we;
    logic [AW-1:0] base;
    logic [LW-1:0] len;
    logic [DW-1:0] wdata;
    logic          o_wreq;
    logic [DW-1:0] o_rdata;
    logic          o_rvalid;
    logic          o_busy;
    logic          o_done;
    logic          o_err;
    logic [AW-1:0] o_addr;
    logic          o_WR;
    logic          o_CS;
    wire  [DW-1:0] dbus;

    int tests = 0;
    int fails = 0;

    logic [DW-1:0] mem     [DEPTH];
    logic [DW-1:0] ref_mem [DEPTH];
    logic [DW-1:0] mem_q;
    logic [DW-1:0] fixed_q [$];

    mem_burst_master #(.DW(DW), .AW(AW), .LW(LW)) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_req   (req),
        .i_we    (we),
        .i_base  (base),
        .i_len   (len),
        .i_wdata (wdata),
        .o_wreq  (o_wreq),
        .o_rdata (o_rdata),
        .o_rvalid(o_rvalid),
        .o_busy  (o_busy),
        .o_done  (o_done),
        .o_err   (o_err),
        .o_addr  (o_addr),
        .o_WR    (o_WR),
        .o_CS    (o_CS),
        .io_dbus (dbus)
    );

    always #5 clk = ~clk;

    // Synchronous SRAM: registered read data, output enabled while selected for read.
    always @(posedge clk) begin
        if (!o_CS && !o_WR) mem_q <= mem[o_addr];
        if (!o_CS && o_WR) mem[o_addr] = dbus;
    end
    assign dbus = (!o_CS && !o_WR) ? mem_q : {DW{1'bz}};

    task automatic check_eq(input string tag, input logic [DW-1:0] got,
                            input logic [DW-1:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit rejects(input int b, input int n);
`ifdef MEM_ADDR_WRAP_EN
        return 1'b0;
`else
        return (n > 0) && (b + n > DEPTH);
`endif
    endfunction

    // One request from accept to the following IDLE cycle, checked every cycle.
    // pre: request already accepted on the edge just passed (chained).
    // chain: keep i_req high with the next request's fields so it chains.
    task automatic do_burst(input bit w, input int b, input int n, input bit pre,
                            input bit chain, input bit cw, input int cb, input int cn);
        logic [DW-1:0] wq [$];
        bit rej;
        int L;
        bit e_act, e_wr, e_busy, e_done, e_err, e_rv;
        rej = rejects(b, n);
        for (int k = 0; k < n; k++) begin
            if (fixed_q.size() > 0) wq.push_back(fixed_q.pop_front());
            else wq.push_back($urandom);
        end
        if (!pre) begin
            req  = 1'b1;
            we   = w;
            base = AW'(b);
            len  = LW'(n);
            @(posedge clk);
            #1;
        end
        if (chain) begin
            we   = cw;
            base = AW'(cb);
            len  = LW'(cn);
        end else begin
            req = 1'b0;
        end
        if (rej || n == 0) L = 2;
        else if (w) L = n + 2;
        else L = n + 3;
        for (int c = 1; c <= L; c++) begin
            if (w && !rej && c <= n) wdata = wq[c-1];
            else wdata = $urandom;
            e_act = 0; e_wr = 0; e_busy = 0; e_done = 0; e_err = 0; e_rv = 0;
            if (rej) begin
                e_err = (c == 1);
            end else if (n == 0) begin
                e_busy = (c == 1);
                e_done = (c == 1);
            end else if (w) begin
                e_act  = (c <= n);
                e_wr   = (c <= n);
                e_busy = (c <= n + 1);
                e_done = (c == n + 1);
            end else begin
                e_act  = (c <= n + 1);
                e_busy = (c <= n + 2);
                e_done = (c == n + 2);
                e_rv   = (c >= 3) && (c <= n + 2);
            end
            @(negedge clk);
            check_eq($sformatf("cs c%0d", c), DW'(o_CS), DW'(!e_act));
            check_eq($sformatf("wr c%0d", c), DW'(o_WR), DW'(e_wr));
            check_eq($sformatf("wreq c%0d", c), DW'(o_wreq), DW'(e_wr));
            check_eq($sformatf("busy c%0d", c), DW'(o_busy), DW'(e_busy));
            check_eq($sformatf("done c%0d", c), DW'(o_done), DW'(e_done));
            check_eq($sformatf("err c%0d", c), DW'(o_err), DW'(e_err));
            check_eq($sformatf("rvalid c%0d", c), DW'(o_rvalid), DW'(e_rv));
            if (e_act)
                check_eq($sformatf("addr c%0d", c), DW'(o_addr),
                         DW'((b + ((c <= n) ? c - 1 : n - 1)) % DEPTH));
            if (e_rv)
                check_eq($sformatf("rdata c%0d", c), o_rdata,
                         ref_mem[(b + c - 3) % DEPTH]);
            if (e_wr)
                check_eq($sformatf("dbus c%0d", c), dbus, wq[c-1]);
            @(posedge clk);
            #1;
        end
        if (w && !rej)
            for (int k = 0; k < n; k++) ref_mem[(b + k) % DEPTH] = wq[k];
    endtask

    function automatic int pick_base();
        if ($urandom_range(0, 3) == 0) return $urandom_range(DEPTH - 24, DEPTH - 1);
        return $urandom_range(0, DEPTH - 1);
    endfunction

    function automatic int pick_len();
        if ($urandom_range(0, 7) == 0) return 0;
        return $urandom_range(1, (1 << LW) - 1);
    endfunction

    initial begin
        logic [DW-1:0] v;
        logic [DW-1:0] w0;
        bit cur_w, nxt_w, pre, ch;
        int cur_b, cur_n, nxt_b, nxt_n;

        for (int i = 0; i < DEPTH; i++) begin
            v = $urandom;
            mem[i] = v;
            ref_mem[i] = v;
        end
        mem[20] = 32'hA; ref_mem[20] = 32'hA;
        mem[21] = 32'hB; ref_mem[21] = 32'hB;
        mem[22] = 32'hC; ref_mem[22] = 32'hC;

        rst = 1'b0; req = 1'b0; we = 1'b0; base = '0; len = '0; wdata = '0;
        #2 rst = 1'b1;
        #1;
        check_eq("rst cs", DW'(o_CS), DW'(1));
        check_eq("rst wr", DW'(o_WR), DW'(0));
        check_eq("rst addr", DW'(o_addr), DW'(0));
        check_eq("rst rdata", o_rdata, DW'(0));
        check_eq("rst rvalid", DW'(o_rvalid), DW'(0));
        check_eq("rst wreq", DW'(o_wreq), DW'(0));
        check_eq("rst busy", DW'(o_busy), DW'(0));
        check_eq("rst done", DW'(o_done), DW'(0));
        check_eq("rst err", DW'(o_err), DW'(0));
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        do_burst(0, 20, 3, 0, 0, 0, 0, 0);
        fixed_q.push_back(32'h11);
        fixed_q.push_back(32'h22);
        do_burst(1, 40, 2, 0, 0, 0, 0, 0);
        do_burst(0, 40, 2, 0, 0, 0, 0, 0);
        do_burst(1, 60, 3, 0, 1, 0, 60, 3);
        do_burst(0, 60, 3, 1, 0, 0, 0, 0);
        do_burst(0, 7, 0, 0, 0, 0, 0, 0);
        do_burst(0, 1022, 4, 0, 0, 0, 0, 0);

        w0 = $urandom;
        req = 1'b1; we = 1'b1; base = AW'(100); len = LW'(8); wdata = w0;
        @(posedge clk);
        #1 req = 1'b0;
        @(negedge clk);
        check_eq("abort c1 cs", DW'(o_CS), DW'(0));
        @(posedge clk);
        #1 wdata = $urandom;
        #2 rst = 1'b1;
        #1;
        check_eq("abort cs", DW'(o_CS), DW'(1));
        check_eq("abort wr", DW'(o_WR), DW'(0));
        check_eq("abort wreq", DW'(o_wreq), DW'(0));
        check_eq("abort busy", DW'(o_busy), DW'(0));
        check_eq("abort done", DW'(o_done), DW'(0));
        check_eq("abort addr", DW'(o_addr), DW'(0));
        @(posedge clk);
        #1 rst = 1'b0;
        ref_mem[100] = w0;
        do_burst(0, 100, 1, 0, 0, 0, 0, 0);

        cur_w = 1'($urandom);
        cur_b = pick_base();
        cur_n = pick_len();
        pre = 0;
        for (int i = 0; i < 60; i++) begin
            nxt_w = 1'($urandom);
            nxt_b = pick_base();
            nxt_n = pick_len();
            ch = !rejects(cur_b, cur_n) && ($urandom_range(0, 1) == 1);
            do_burst(cur_w, cur_b, cur_n, pre, ch, nxt_w, nxt_b, nxt_n);
            pre = ch;
            cur_w = nxt_w;
            cur_b = nxt_b;
            cur_n = nxt_n;
        end
        do_burst(cur_w, cur_b, cur_n, pre, 0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
